// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a req/gnt/rvalid data-memory port and registers the MEM/WB outputs.
// Optional macro MEM_MISALIGN_CHECK_EN suppresses misaligned halfword/word accesses instead of issuing them.
package mem_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW
  } alu_ctrl_e;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pcM_i,
  input  logic [XLEN-1:0] instrM_i,
  input  alu_ctrl_e       operationM_i,
  input  logic [XLEN-1:0] rdM_data_i,
  input  logic [4:0]      rdM_addr_i,
  input  logic            rdM_wr_ena_i,
  input  logic            tb_update_i,
  input  logic            memM_wr_ena_i,
  input  logic [XLEN-1:0] memM_addr_i,
  input  logic [XLEN-1:0] memM_wr_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] forwM_data_o,
  output logic [XLEN-1:0] pcW_o,
  output logic [XLEN-1:0] instrW_o,
  output logic [XLEN-1:0] rdW_data_o,
  output logic [4:0]      rdW_addr_o,
  output logic            rdW_wr_ena_o,
  output logic            tb_update_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RVALID} state_e;

  state_e     state_q, state_d;
  logic       is_load, is_store, misaligned, mem_op, req, done;
  logic [1:0] off;

  function automatic logic [3:0] lane_mask(alu_ctrl_e op, logic [1:0] o);
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: lane_mask = 4'b0001 << o;
      ALU_LH, ALU_LHU, ALU_SH: lane_mask = 4'b0011 << o;
      default:                 lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(alu_ctrl_e op, logic [XLEN-1:0] d);
    case (op)
      ALU_SB:  store_data = {(XLEN/8){d[7:0]}};
      ALU_SH:  store_data = {(XLEN/16){d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Lanes shifted past byte 3 fall off the top, so misaligned halfwords keep only the low byte.
  function automatic logic [XLEN-1:0] load_data(alu_ctrl_e op, logic [1:0] o, logic [XLEN-1:0] rd);
    logic [XLEN-1:0] sh;
    sh = rd >> {o, 3'b000};
    case (op)
      ALU_LB:  load_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      ALU_LBU: load_data = {{(XLEN-8){1'b0}}, sh[7:0]};
      ALU_LH:  load_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      ALU_LHU: load_data = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: load_data = rd;
    endcase
  endfunction

  assign off      = memM_addr_i[1:0];
  assign is_load  = operationM_i inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  assign is_store = memM_wr_ena_i && (operationM_i inside {ALU_SB, ALU_SH, ALU_SW});

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (operationM_i)
      ALU_LH, ALU_LHU, ALU_SH: misaligned = off[0];
      ALU_LW, ALU_SW:          misaligned = |off;
      default:                 misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign mem_op = (is_load || is_store) && !misaligned;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT_GNT: begin
        if (mem_op) begin
          req = 1'b1;
          if (dmem_gnt_i) begin
            done    = is_store;
            state_d = is_store ? S_IDLE : S_WAIT_RVALID;
          end else begin
            state_d = S_WAIT_GNT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request side is purely combinational from the held M-stage inputs, so it stays stable while stalled.
  assign dmem_req_o   = req && !rst_i;
  assign dmem_we_o    = req && is_store && !rst_i;
  assign dmem_be_o    = lane_mask(operationM_i, off);
  assign dmem_addr_o  = {memM_addr_i[XLEN-1:2], 2'b00};
  assign dmem_wdata_o = store_data(operationM_i, memM_wr_data_i);
  assign stall_o      = mem_op && !done && !rst_i;
  assign forwM_data_o = rdM_data_i;

  // MEM/WB boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcW_o        <= XLEN'(32'h8000_0000);
      instrW_o     <= XLEN'(32'h0000_0013);
      rdW_data_o   <= '0;
      rdW_addr_o   <= '0;
      rdW_wr_ena_o <= 1'b0;
      tb_update_o  <= 1'b0;
    end else if (stall_o) begin
      rdW_wr_ena_o <= 1'b0;
      tb_update_o  <= 1'b0;
    end else begin
      pcW_o        <= pcM_i;
      instrW_o     <= instrM_i;
      rdW_addr_o   <= rdM_addr_i;
      rdW_wr_ena_o <= rdM_wr_ena_i && !misaligned;
      tb_update_o  <= tb_update_i;
      rdW_data_o   <= (is_load && mem_op) ? load_data(operationM_i, off, dmem_rdata_i) : rdM_data_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-lane reference model and a per-cycle compare process.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pcM_i = 32'h8000_0000, instrM_i = 32'h13, rdM_data_i = '0;
  alu_ctrl_e   operationM_i = ALU_ADD;
  logic [4:0]  rdM_addr_i = '0, rdW_addr_o;
  logic        rdM_wr_ena_i = 1'b0, tb_update_i = 1'b0, memM_wr_ena_i = 1'b0;
  logic [31:0] memM_addr_i = '0, memM_wr_data_i = '0;
  logic        dmem_req_o, dmem_we_o, stall_o, rdW_wr_ena_o, tb_update_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, forwM_data_o, pcW_o, instrW_o, rdW_data_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  mem_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pcM_i(pcM_i), .instrM_i(instrM_i),
    .operationM_i(operationM_i), .rdM_data_i(rdM_data_i), .rdM_addr_i(rdM_addr_i),
    .rdM_wr_ena_i(rdM_wr_ena_i), .tb_update_i(tb_update_i), .memM_wr_ena_i(memM_wr_ena_i),
    .memM_addr_i(memM_addr_i), .memM_wr_data_i(memM_wr_data_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .forwM_data_o(forwM_data_o),
    .pcW_o(pcW_o), .instrW_o(instrW_o), .rdW_data_o(rdW_data_o), .rdW_addr_o(rdW_addr_o),
    .rdW_wr_ena_o(rdW_wr_ena_o), .tb_update_o(tb_update_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;
  int req_cnt = 0, stall_cnt = 0;
  logic retire = 1'b1, exp_req = 1'b0, exp_stall = 1'b0, chk_en = 1'b0;
  logic [31:0] ld_val = '0;
  logic [31:0] e_pc, e_instr, e_data;
  logic [4:0]  e_addr;
  logic        e_wr, e_tb;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_size(alu_ctrl_e op);
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: return 1;
      ALU_LH, ALU_LHU, ALU_SH: return 2;
      ALU_LW, ALU_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_ld(alu_ctrl_e op);
    return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction

  function automatic bit is_st(alu_ctrl_e op);
    return op inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic bit is_mis(alu_ctrl_e op, logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
    int sz = op_size(op);
    return (sz > 1) && ((int'(addr[1:0]) % sz) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(alu_ctrl_e op, logic [31:0] addr);
    int sz = op_size(op);
    int o = int'(addr[1:0]);
    logic [3:0] m = '0;
    if (sz == 4) return 4'hF;
    for (int k = 0; k < sz; k++) if (o + k < 4) m[o+k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(alu_ctrl_e op, logic [31:0] d);
    logic [31:0] b = d & 32'h0000_00FF;
    logic [31:0] h = d & 32'h0000_FFFF;
    case (op_size(op))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(alu_ctrl_e op, logic [31:0] addr, logic [31:0] rd);
    int sz = op_size(op);
    int o = int'(addr[1:0]);
    longint v = 0;
    longint one = 1;
    if (sz == 4) return rd;
    for (int k = 0; k < sz; k++)
      if (o + k < 4) v += longint'(rd[8*(o+k) +: 8]) << (8*k);
    if ((op == ALU_LB || op == ALU_LH) && v >= (one << (8*sz - 1))) v -= (one << (8*sz));
    return v[31:0];
  endfunction

  // Reference model of the registered W outputs: retire when the bench knows the instruction completes.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_pc <= 32'h8000_0000; e_instr <= 32'h13; e_data <= '0; e_addr <= '0; e_wr <= 1'b0; e_tb <= 1'b0;
    end else if (retire) begin
      e_pc    <= pcM_i;
      e_instr <= instrM_i;
      e_addr  <= rdM_addr_i;
      e_tb    <= tb_update_i;
      e_wr    <= rdM_wr_ena_i && !is_mis(operationM_i, memM_addr_i);
      e_data  <= (is_ld(operationM_i) && !is_mis(operationM_i, memM_addr_i)) ? ld_val : rdM_data_i;
    end else begin
      e_wr <= 1'b0;
      e_tb <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("req", dmem_req_o, exp_req);
      check("stall", stall_o, exp_stall);
      check("fwd", forwM_data_o, rdM_data_i);
      check("pcW", pcW_o, e_pc);
      check("instrW", instrW_o, e_instr);
      check("rdW_data", rdW_data_o, e_data);
      check("rdW_addr", rdW_addr_o, e_addr);
      check("rdW_wr", rdW_wr_ena_o, e_wr);
      check("tbW", tb_update_o, e_tb);
      if (exp_req) begin
        check("addr", dmem_addr_o, memM_addr_i & 32'hFFFF_FFFC);
        check("be", dmem_be_o, m_be(operationM_i, memM_addr_i));
        check("we", dmem_we_o, is_st(operationM_i));
        if (is_st(operationM_i)) check("wdata", dmem_wdata_o, m_wdata(operationM_i, memM_wr_data_i));
      end
      if (dmem_req_o) req_cnt++;
      if (stall_o) stall_cnt++;
    end
  end

  task automatic do_op(alu_ctrl_e op, logic [31:0] pc, logic [31:0] addr, logic [31:0] data,
                       logic [4:0] rd, logic wr, int gd, int rv_dly, logic [31:0] rdata);
    bit mem = (is_ld(op) || is_st(op)) && !is_mis(op, addr);
    @(posedge clk_i); #1;
    operationM_i = op; pcM_i = pc; instrM_i = pc ^ 32'h0000_0013;
    rdM_data_i = data; rdM_addr_i = rd; rdM_wr_ena_i = wr; tb_update_i = 1'b1;
    memM_wr_ena_i = is_st(op); memM_addr_i = addr; memM_wr_data_i = data;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0BAD_0BAD; dmem_gnt_i = 1'b0;
    if (!mem) begin
      exp_req = 1'b0; exp_stall = 1'b0; retire = 1'b1;
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      if (i > 0) begin @(posedge clk_i); #1; end
      dmem_gnt_i = (i == gd);
      exp_req    = 1'b1;
      exp_stall  = is_ld(op) || (i != gd);
      retire     = is_st(op) && (i == gd);
    end
    if (is_ld(op)) begin
      for (int j = 0; j <= rv_dly; j++) begin
        @(posedge clk_i); #1;
        dmem_gnt_i    = 1'b0;
        exp_req       = 1'b0;
        dmem_rvalid_i = (j == rv_dly);
        dmem_rdata_i  = (j == rv_dly) ? rdata : 32'h0BAD_0BAD;
        ld_val        = m_load(op, addr, rdata);
        exp_stall     = (j != rv_dly);
        retire        = (j == rv_dly);
      end
    end
  endtask

  task automatic nop(logic [31:0] pc);
    do_op(ALU_ADD, pc, 32'h0, 32'h0, 5'd0, 1'b0, 0, 0, 32'h0);
  endtask

  initial begin
    #1 rst_i = 1'b1;
    #1 chk_en = 1'b1;
    #1;
    check("rst_pcW", pcW_o, 32'h8000_0000);
    check("rst_instrW", instrW_o, 32'h13);
    check("rst_rdW_data", rdW_data_o, 32'h0);
    check("rst_rdW_wr", rdW_wr_ena_o, 1'b0);
    check("rst_tbW", tb_update_o, 1'b0);
    check("rst_req", dmem_req_o, 1'b0);
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;

    do_op(ALU_ADD, 32'h8000_0000, 32'h0, 32'h7, 5'd5, 1'b1, 0, 0, 32'h0);
    #2 check("add_req", dmem_req_o, 1'b0);
    nop(32'h8000_0004);
    #2;
    check("add_rdW_data", rdW_data_o, 32'h7);
    check("add_rdW_addr", rdW_addr_o, 32'd5);

    stall_cnt = 0;
    do_op(ALU_SW, 32'h8000_0008, 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 0, 32'h0);
    #2;
    check("sw_be", dmem_be_o, 4'b1111);
    check("sw_addr", dmem_addr_o, 32'h100);
    check("sw_stall", stall_o, 1'b0);
    check("sw_wdata", dmem_wdata_o, 32'hDEAD_BEEF);
    nop(32'h8000_000C);
    #2 check("sw_rdW_wr", rdW_wr_ena_o, 1'b0);

    stall_cnt = 0;
    do_op(ALU_LB, 32'h8000_0010, 32'h103, 32'h103, 5'd6, 1'b1, 0, 0, 32'h80FF_FF7F);
    nop(32'h8000_0014);
    #2;
    check("lb_stall_cycles", stall_cnt, 1);
    check("lb_rdW_data", rdW_data_o, 32'hFFFF_FF80);

    req_cnt = 0;
    do_op(ALU_LHU, 32'h8000_0018, 32'h102, 32'h102, 5'd7, 1'b1, 3, 1, 32'hABCD_1234);
    nop(32'h8000_001C);
    #2;
    check("lhu_req_cycles", req_cnt, 4);
    check("lhu_rdW_data", rdW_data_o, 32'h0000_ABCD);

    do_op(ALU_SB, 32'h8000_0020, 32'h101, 32'h55, 5'd0, 1'b0, 0, 0, 32'h0);
    #2;
    check("sb_be", dmem_be_o, 4'b0010);
    check("sb_wdata", dmem_wdata_o, 32'h5555_5555);

    do_op(ALU_SH, 32'h8000_0024, 32'h202, 32'h1234_BEEF, 5'd0, 1'b0, 2, 0, 32'h0);
    do_op(ALU_LW, 32'h8000_0028, 32'h204, 32'h204, 5'd8, 1'b1, 1, 2, 32'h1357_9BDF);
    do_op(ALU_LBU, 32'h8000_002C, 32'h302, 32'h302, 5'd9, 1'b1, 0, 0, 32'h00C3_0000);
    do_op(ALU_LH, 32'h8000_0030, 32'h103, 32'h103, 5'd10, 1'b1, 1, 0, 32'h8011_2233);
    do_op(ALU_SUB, 32'h8000_0034, 32'h0, 32'hFFFF_FFF0, 5'd11, 1'b1, 0, 0, 32'h0);
    nop(32'h8000_0038);

    do_op(ALU_LW, 32'h8000_0040, 32'h400, 32'h400, 5'd12, 1'b1, 0, 5, 32'hCAFE_F00D);
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0; exp_req = 1'b0; exp_stall = 1'b1; retire = 1'b0;
    #2;
    rst_i = 1'b1;
    operationM_i = ALU_ADD; rdM_wr_ena_i = 1'b0; memM_wr_ena_i = 1'b0; rdM_data_i = '0;
    exp_stall = 1'b0; retire = 1'b1;
    #1;
    check("midrst_req", dmem_req_o, 1'b0);
    check("midrst_pcW", pcW_o, 32'h8000_0000);
    check("midrst_instrW", instrW_o, 32'h13);
    check("midrst_rdW_wr", rdW_wr_ena_o, 1'b0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    do_op(ALU_ADD, 32'h8000_0044, 32'h0, 32'h1234, 5'd13, 1'b1, 0, 0, 32'h0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    nop(32'h8000_0048);
    #2;
    check("late_rvalid_data", rdW_data_o, 32'h1234);
    check("late_rvalid_stall", stall_o, 1'b0);
    nop(32'h8000_004C);
    repeat (2) @(posedge clk_i);
    #1 chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports pcM_i, instrM_i  input  XLEN  PC and instruction from execute.
REQ-005 SHALL have ports operationM_i (alu_ctrl_e), rdM_data_i (XLEN), rdM_addr_i (5), rdM_wr_ena_i (1), tb_update_i (1)  input  execute results.
REQ-006 SHALL have ports memM_wr_ena_i (1), memM_addr_i (XLEN), memM_wr_data_i (XLEN)  input  store enable, byte address, store data.
REQ-007 SHALL have ports dmem_req_o (1), dmem_we_o (1), dmem_be_o (4), dmem_addr_o (XLEN), dmem_wdata_o (XLEN)  output  data-memory request.
REQ-008 SHALL have ports dmem_gnt_i (1), dmem_rvalid_i (1), dmem_rdata_i (XLEN)  input  grant, read-valid, read data.
REQ-009 SHALL have port stall_o  output  1  hold request to upstream stages.
REQ-010 SHALL have port forwM_data_o  output  XLEN  combinational forward value, equals rdM_data_i.
REQ-011 SHALL have ports pcW_o, instrW_o, rdW_data_o (XLEN), rdW_addr_o (5), rdW_wr_ena_o (1), tb_update_o (1)  output  registered MEM/WB outputs.

Function
REQ-012 SHALL treat LB/LH/LW/LBU/LHU as loads, SB/SH/SW as stores, all other operations as pass-through.
REQ-013 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RVALID; reset state IDLE.
REQ-014 SHALL, in IDLE with load/store present, assert dmem_req_o combinationally; dmem_addr_o = {memM_addr_i[XLEN-1:2],2'b00}; dmem_we_o=1 for stores.
REQ-015 SHALL hold req, we, be, addr, wdata stable from first assertion until dmem_gnt_i sampled high (IDLE->WAIT_GNT if no grant).
REQ-016 SHALL on grant: store completes that cycle, FSM to IDLE; load moves to WAIT_RVALID, req deasserted next cycle.
REQ-017 SHALL complete a load on dmem_rvalid_i high in WAIT_RVALID, FSM to IDLE; rvalid in any other state ignored.
REQ-018 SHALL drive dmem_be_o: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; loads likewise by size.
REQ-019 SHALL replicate store data: SB byte x4, SH half x2, SW word.
REQ-020 SHALL extract load data from dmem_rdata_i by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-021 SHALL assert stall_o combinationally whenever a load/store is present and not completing this cycle (zero-wait store: 0 stall cycles; load: at least 1).
REQ-022 SHALL, while stall_o high, register a bubble: rdW_wr_ena_o=0, tb_update_o=0, other W outputs unchanged.
REQ-023 SHALL on completion or pass-through register pc, instr, rd addr, wr enable, tb_update; rdW_data_o = load data for loads, rdM_data_i otherwise.
REQ-024 SHALL have 1-cycle latency for pass-through operations.

Reset
REQ-025 SHALL on rst_i high immediately: FSM IDLE, dmem_req_o 0, pcW_o 32'h8000_0000, instrW_o 32'h00000013, rdW_data_o 0, rdW_addr_o 0, rdW_wr_ena_o 0, tb_update_o 0.
REQ-026 SHALL abandon any in-flight access on reset mid-operation; a late rvalid after reset is ignored.

Configuration
REQ-027 SHALL, with MEM_MISALIGN_CHECK_EN defined, flag LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as misaligned: no dmem request, no stall, rdW_wr_ena_o=0, tb_update passed.
REQ-028 SHALL, without MEM_MISALIGN_CHECK_EN, issue misaligned accesses unchecked using the lane rules of REQ-018/020 (lanes beyond byte 3 dropped).

Verification
REQ-029 SW addr 0x100 data 0xDEADBEEF, gnt same cycle -> be 1111, addr 0x100, stall_o 0, rdW_wr_ena_o 0 next cycle.
REQ-030 LB addr 0x103, gnt same cycle, rvalid next cycle rdata 0x80FF_FF7F -> 1 stall cycle, rdW_data_o 0xFFFFFF80.
REQ-031 LHU addr 0x102, gnt delayed 3 cycles, rdata 0xABCD1234 -> req stable 4 cycles, rdW_data_o 0x0000ABCD.
REQ-032 SB addr 0x101 data 0x55 -> be 0010, wdata 0x55555555.
REQ-033 ADD result 0x7 rd 5 -> rdW_data_o 0x7, rdW_addr_o 5 one cycle later, dmem_req_o 0.
REQ-034 rst_i pulse during WAIT_RVALID -> req 0, IDLE, W outputs reset; subsequent rvalid ignored.
